// File: rtl/pc_fetch.sv
// Program counter and fetch stage with call/return stack; RAS_WRAP_EN makes the stack circular on overflow.
// Latency: instruction at address A reaches ir one clk edge after pc=A; address is the pc register.
// Backpressure: stall freezes pc, ir and stack; controls are honoured only on a valid, unstalled ir.
module pc_fetch #(
    parameter int p_size   = 6,
    parameter int i_size   = 24,
    parameter int rs_depth = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [p_size-1:0] address,
    input  logic [i_size-1:0] instr_in,
    output logic [i_size-1:0] ir,
    output logic [p_size-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              stall,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [p_size-1:0] jump_addr,
    output logic              rs_empty,
    output logic              rs_full,
    output logic              err
);
    localparam int cnt_w = $clog2(rs_depth + 1);
    localparam int ptr_w = $clog2(rs_depth);
    localparam logic [cnt_w-1:0] cnt_max  = cnt_w'(rs_depth);
    localparam logic [ptr_w-1:0] ptr_last = ptr_w'(rs_depth - 1);
`ifdef RAS_WRAP_EN
    localparam bit wrap_en = 1'b1;
`else
    localparam bit wrap_en = 1'b0;
`endif

    logic [p_size-1:0] pc;
    logic [p_size-1:0] ras [rs_depth];
    logic [ptr_w-1:0]  sp;
    logic [ptr_w-1:0]  sp_inc;
    logic [ptr_w-1:0]  sp_dec;
    logic [cnt_w-1:0]  count;
    logic [p_size-1:0] ret_addr;
    logic              ctl_ok;
    logic              take_ret;
    logic              take_call;
    logic              take_jump;
    logic              push_en;

    assign address   = pc;
    assign rs_empty  = (count == '0);
    assign rs_full   = (count == cnt_max);
    assign ret_addr  = ir_pc + 1'b1;

    // sp is the next free slot; in the circular build it also marks the oldest entry when full
    assign sp_inc    = (sp == ptr_last) ? '0 : sp + 1'b1;
    assign sp_dec    = (sp == '0) ? ptr_last : sp - 1'b1;

    assign ctl_ok    = ir_valid & ~stall;
    assign take_ret  = ctl_ok & ret;
    assign take_call = ctl_ok & call & ~ret;
    assign take_jump = ctl_ok & jump & ~ret & ~call;
    assign push_en   = take_call & (~rs_full | wrap_en);

    always_ff @(posedge clk) begin
        if (push_en) begin
            ras[sp] <= ret_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            sp       <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else if (!stall) begin
            ir       <= instr_in;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (take_ret) begin
                ir_valid <= 1'b0;
                if (rs_empty) begin
                    pc  <= '0;
                    err <= 1'b1;
                end else begin
                    pc    <= ras[sp_dec];
                    sp    <= sp_dec;
                    count <= count - 1'b1;
                end
            end else if (take_call) begin
                ir_valid <= 1'b0;
                pc       <= jump_addr;
                if (!rs_full) begin
                    sp    <= sp_inc;
                    count <= count + 1'b1;
                end else if (wrap_en) begin
                    sp <= sp_inc;
                end else begin
                    err <= 1'b1;
                end
            end else if (take_jump) begin
                ir_valid <= 1'b0;
                pc       <= jump_addr;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: stimulus task predicts post-edge state from a queue-based model, monitor compares.
module tb_pc_fetch;
    localparam int RS_DEPTH = 4;

    typedef struct {
        logic [5:0]  addr;
        logic [23:0] ir;
        logic [5:0]  irpc;
        logic        irv;
        logic        empty;
        logic        full;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  address;
    logic [23:0] instr_in;
    logic [23:0] ir;
    logic [5:0]  ir_pc;
    logic        ir_valid;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [5:0]  jump_addr = '0;
    logic        rs_empty;
    logic        rs_full;
    logic        err;

    logic [23:0] mem [64];
    exp_t        exp_q [$];

    logic [5:0]  m_pc, m_irpc;
    logic [23:0] m_ir;
    logic        m_irv, m_err;
    logic [5:0]  m_rs [$];

    int n_chk = 0;
    int n_fail = 0;

    assign instr_in = mem[address];

    always #5 clk = ~clk;

    pc_fetch #(.p_size(6), .i_size(24), .rs_depth(RS_DEPTH)) dut (
        .clk(clk), .reset(reset), .address(address), .instr_in(instr_in),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .stall(stall),
        .jump(jump), .call(call), .ret(ret), .jump_addr(jump_addr),
        .rs_empty(rs_empty), .rs_full(rs_full), .err(err)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_ir = '0; m_irpc = '0; m_irv = 1'b0; m_err = 1'b0;
        m_rs.delete();
    endtask

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic step(bit r, bit s, bit j, bit c, bit rt, logic [5:0] ja);
        exp_t       e;
        logic [5:0] old_irpc;
        bit         ctl;
        @(negedge clk);
        reset = r; stall = s; jump = j; call = c; ret = rt; jump_addr = ja;
        if (r) begin
            model_reset();
        end else if (!s) begin
            ctl      = m_irv;
            old_irpc = m_irpc;
            m_ir     = mem[m_pc];
            m_irpc   = m_pc;
            m_irv    = 1'b1;
            if (ctl && rt) begin
                m_irv = 1'b0;
                if (m_rs.size() == 0) begin
                    m_pc  = '0;
                    m_err = 1'b1;
                end else begin
                    m_pc = m_rs.pop_back();
                end
            end else if (ctl && c) begin
                m_irv = 1'b0;
                m_pc  = ja;
                if (m_rs.size() == RS_DEPTH) begin
`ifdef RAS_WRAP_EN
                    void'(m_rs.pop_front());
                    m_rs.push_back(old_irpc + 6'd1);
`else
                    m_err = 1'b1;
`endif
                end else begin
                    m_rs.push_back(old_irpc + 6'd1);
                end
            end else if (ctl && j) begin
                m_irv = 1'b0;
                m_pc  = ja;
            end else begin
                m_pc = m_pc + 6'd1;
            end
        end
        e.addr  = m_pc;
        e.ir    = m_ir;
        e.irpc  = m_irpc;
        e.irv   = m_irv;
        e.empty = (m_rs.size() == 0);
        e.full  = (m_rs.size() == RS_DEPTH);
        e.err   = m_err;
        exp_q.push_back(e);
    endtask

    task automatic nop(int n);
        repeat (n) step(0, 0, 0, 0, 0, 6'd0);
    endtask

    // Reset raised between edges must clear state with no clock edge.
    task automatic async_reset_check();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_address", 32'(address), 32'd0);
        chk("async_ir_valid", 32'(ir_valid), 32'd0);
        chk("async_rs_empty", 32'(rs_empty), 32'd1);
        chk("async_err", 32'(err), 32'd0);
        model_reset();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("address", 32'(address), 32'(e.addr));
            chk("ir", 32'(ir), 32'(e.ir));
            chk("ir_pc", 32'(ir_pc), 32'(e.irpc));
            chk("ir_valid", 32'(ir_valid), 32'(e.irv));
            chk("rs_empty", 32'(rs_empty), 32'(e.empty));
            chk("rs_full", 32'(rs_full), 32'(e.full));
            chk("err", 32'(err), 32'(e.err));
        end
    end

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 24'(k + 'h100);
        model_reset();

        // straight-line fetch with address wrap
        repeat (3) step(1, 0, 0, 0, 0, 6'd0);
        nop(70);
        async_reset_check();
        step(1, 0, 0, 0, 0, 6'd0);

        // stall at pc=5 with an ignored jump, then jump/flush from ir_pc=4
        nop(5);
        step(0, 1, 0, 0, 0, 6'd0);
        step(0, 1, 1, 0, 0, 6'h20);
        step(0, 1, 0, 0, 0, 6'd0);
        nop(1);
        step(1, 0, 0, 0, 0, 6'd0);
        nop(5);
        step(0, 0, 1, 0, 0, 6'h20);
        step(0, 0, 1, 0, 0, 6'h10);
        nop(2);

        // call at ir_pc=3 then return at ir_pc=0x31
        step(1, 0, 0, 0, 0, 6'd0);
        nop(4);
        step(0, 0, 0, 1, 0, 6'h30);
        nop(2);
        step(0, 0, 0, 0, 1, 6'd0);
        nop(2);

        // five nested calls, then five returns
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0, 6'(8 + 8 * i));
            nop(1);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 6'd0);
            nop(1);
        end
        nop(3);

        // underflow with simultaneous call/ret priority, err stays sticky
        step(1, 0, 0, 0, 0, 6'd0);
        nop(2);
        step(0, 0, 1, 1, 1, 6'h15);
        nop(4);

        // randomized mix, including resets mid-stall
        step(1, 0, 0, 0, 0, 6'd0);
        for (int k = 0; k < 64; k++) mem[k] = 24'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) async_reset_check();
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 6) == 0), 6'($urandom));
        end
        nop(2);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Program counter and fetch stage for the processor. Drives the combinational program-memory address and latches the returned instruction into an instruction register (IR) for decode. Supports stall, absolute jump, and call/return through a small hardware return-address stack (RAS). Decode consumes IR and feeds control back into this block.

Parameters:
p_size, 6, program address width; PC wraps modulo 2^p_size.
i_size, 24, instruction width; must match the program-memory word.
rs_depth, 4, RAS entries, legal range 2..16.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
address  output  p_size  program-memory address; equals the PC register, no combinational path from inputs
instr_in  input  i_size  instruction returned by program memory for the current address
ir  output  i_size  registered instruction to decode
ir_pc  output  p_size  address from which ir was fetched
ir_valid  output  1  ir holds a valid in-path instruction
stall  input  1  hold all state this cycle
jump  input  1  absolute jump to jump_addr; qualified by ir_valid
call  input  1  push ir_pc+1, then go to jump_addr; qualified by ir_valid
ret  input  1  pop return address into PC; qualified by ir_valid
jump_addr  input  p_size  jump or call target
rs_empty  output  1  RAS holds 0 entries
rs_full  output  1  RAS holds rs_depth entries
err  output  1  sticky RAS error flag; cleared only by reset

Behaviour:
- Reset, asynchronous and active-high, has priority over everything:
  - pc=0, ir=0, ir_pc=0, ir_valid=0, RAS count=0, err=0.
- address = pc at all times, so program memory sees address 0 during reset.
- Latency: the instruction at address A appears on ir one clock edge after pc=A.
- First edge after reset release: ir=mem[0], ir_pc=0, ir_valid=1, pc=1.
- Controls (jump, call, ret) are honoured only when ir_valid=1 and stall=0. Otherwise they are ignored.
- Per-edge priority: stall > ret > call > jump > sequential.
  - stall=1: pc, ir, ir_pc, ir_valid and RAS all hold. err holds.
  - Sequential: ir<=instr_in, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (wraps 2^p_size-1 -> 0).
  - jump: pc<=jump_addr, ir_valid<=0 (flushes the wrong-path fetch). ir and ir_pc still load instr_in/pc; decode must ignore them.
  - call: push (ir_pc+1) mod 2^p_size, pc<=jump_addr, ir_valid<=0.
  - ret: pop the top entry into pc, ir_valid<=0.
- Because the flush forces ir_valid=0, a control asserted one cycle can never be re-honoured the next cycle.
- RAS is LIFO. rs_empty = (count==0); rs_full = (count==rs_depth).
- ret when empty: pc<=0, err<=1, count stays 0.
- call when full: see Optional Feature.
- Simultaneous call and ret: ret wins, no push occurs. Simultaneous jump with call or ret: the higher-priority control wins.
- Reset mid-operation, including mid-stall: immediate return to the reset state. RAS contents are discarded.
- All registers update only on the rising edge of clk, except for the asynchronous reset.

Optional Feature:
RAS_WRAP_EN
- Defined: RAS is circular. A call when full overwrites the oldest entry, count stays rs_depth, and err is not set.
- Undefined: a call when full still redirects pc<=jump_addr, but the push is dropped, count stays rs_depth, and err<=1.
- Underflow behaviour (ret when empty) is identical in both builds.

Test Plan:
- Reset, then straight-line fetch: mem[k]=k+0x100, reset held 3 cycles and released -> address 0,1,2,3 on successive edges; ir=0x000100,0x000101,... with ir_pc lagging address by one; ir_valid=1 from the first edge. Reassert reset mid-run -> address=0 and ir_valid=0 with no clock edge.
- Wrap: run 64 fetches with p_size=6 -> address goes 63 -> 0; ir_pc=63 followed by ir_pc=0.
- Stall: assert stall for 3 cycles while pc=5 -> address stays 5, ir and ir_valid unchanged. Assert jump during the stall -> ignored. Release -> next edge ir_pc=5.
- Jump and flush: ir_pc=4 valid, jump=1, jump_addr=0x20 -> next edge pc=0x20 and ir_valid=0; following edge ir_pc=0x20 and ir_valid=1. Assert jump while ir_valid=0 -> no effect.
- Call/return: call at ir_pc=3 to 0x30, then ret at ir_pc=0x31 -> pc=4. Nest 4 calls -> rs_full=1, rs_empty=0; 4 rets return in LIFO order; rs_empty=1 at the end.
- Errors: ret on an empty RAS -> pc=0, err=1, err holds through later normal operation. Fifth call with rs_depth=4 -> err=1 when RAS_WRAP_EN is undefined; with RAS_WRAP_EN defined -> err=0, and the later 4 rets return the newest 4 addresses.
